// File: rtl/fd_pkg.sv
// ----------------------------------------------------------------------------
// fd_pkg
//   Shared definitions for the fetch/decode stage:
//     - 5-bit opcode encodings (instr[31:27])
//     - instruction field bit positions
//     - 2-bit branch-history counter encodings, reset value and update rule
//     - opcode classification helper returning a packed flag struct
// ----------------------------------------------------------------------------
package fd_pkg;

   // Opcode field
   localparam int OP_MSB = 31;
   localparam int OP_LSB = 27;

   localparam logic [4:0] OP_J   = 5'b00001;
   localparam logic [4:0] OP_BNE = 5'b00010;
   localparam logic [4:0] OP_JAL = 5'b00011;
   localparam logic [4:0] OP_JR  = 5'b00100;
   localparam logic [4:0] OP_BLT = 5'b00110;
   localparam logic [4:0] OP_SW  = 5'b00111;
   localparam logic [4:0] OP_BEX = 5'b10110;

   // Register fields
   localparam int RB_MSB  = 26;   // second source for SW/JR/BNE/BLT
   localparam int RB_LSB  = 22;
   localparam int RA_MSB  = 21;   // first source, all formats
   localparam int RA_LSB  = 17;
   localparam int RT_MSB  = 16;   // second source for the remaining formats
   localparam int RT_LSB  = 12;

   // Immediate / target fields
   localparam int IMM_MSB = 16;   // 17-bit signed branch offset, bit 16 is the sign
   localparam int JT_MSB  = 26;   // 27-bit absolute jump target
   localparam int JT_W    = 27;
   localparam int IMM_W   = 17;

   // Branch-history counter encodings
   localparam logic [1:0] CTR_SNT   = 2'b00;   // strongly not-taken
   localparam logic [1:0] CTR_WNT   = 2'b01;   // weakly not-taken
   localparam logic [1:0] CTR_ST    = 2'b11;   // strongly taken
   localparam logic [1:0] CTR_RESET = CTR_WNT;
   localparam int         PRED_BIT  = 1;       // prediction is the counter MSB

   // Classified opcode
   typedef struct packed {
      logic jump;      // J
      logic jal;       // JAL
      logic cond_br;   // BNE or BLT
      logic jr;        // JR
      logic sw;        // SW
      logic bex;       // BEX
   } dec_flags_t;

   // Classify an opcode into the control flags used by the stage
   function automatic dec_flags_t decode_op(input logic [4:0] op);
      dec_flags_t f;
      f = '{default: 1'b0};
      case (op)
         OP_J:    f.jump    = 1'b1;
         OP_JAL:  f.jal     = 1'b1;
         OP_BNE:  f.cond_br = 1'b1;
         OP_BLT:  f.cond_br = 1'b1;
         OP_JR:   f.jr      = 1'b1;
         OP_SW:   f.sw      = 1'b1;
         OP_BEX:  f.bex     = 1'b1;
         default: f         = '{default: 1'b0};
      endcase
      return f;
   endfunction

   // Two-bit saturating counter step: +1 on taken, -1 on not-taken, clamped at 0 and 3
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (ctr == CTR_ST) ? CTR_ST : (ctr + 2'b01);
      end else begin
         nxt = (ctr == CTR_SNT) ? CTR_SNT : (ctr - 2'b01);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/fd_bht.sv
// ----------------------------------------------------------------------------
// fd_bht
//   Table of 2-bit saturating branch-history counters. One combinational
//   lookup port and one registered update port. A lookup of the entry being
//   updated in the same cycle returns the pre-update value (the write lands
//   on the clock edge). All counters reset to weakly not-taken.
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   lookup_idx  in   entry read combinationally
//   upd_valid   in   apply an update this cycle
//   upd_idx     in   entry to update
//   upd_taken   in   resolved direction (1 = taken)
//   lookup_ctr  out  counter value at lookup_idx
// ----------------------------------------------------------------------------
module fd_bht
   import fd_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [IDX_W-1:0] lookup_idx,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken,
   output logic [1:0]       lookup_ctr
);

   logic [1:0] ctr_r [DEPTH];

   // Counter storage: async clear to weakly not-taken, saturating update on resolve
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctr_r[i] <= CTR_RESET;
         end
      end else if (upd_valid) begin
         ctr_r[upd_idx] <= ctr_next(ctr_r[upd_idx], upd_taken);
      end
   end

   assign lookup_ctr = ctr_r[lookup_idx];

endmodule

// File: rtl/fd_decode_stage.sv
// ----------------------------------------------------------------------------
// fd_decode_stage
//   Registered fetch/decode stage. Latches the fetched PC/instruction, decodes
//   register read addresses, resolves J/JAL targets and predicts BNE/BLT, and
//   issues a one-cycle fetch redirect for the first cycle an instruction sits
//   in the latch. The wrong-path instruction arriving behind a redirect is
//   discarded.
//
// Build option
//   FD_BHT_EN  defined:   dynamic prediction from a BHT indexed by the low PC
//                         bits, trained from execute (ex_upd_*).
//              undefined: no BHT; static backward-taken/forward-not-taken
//                         (prediction = sign bit of the branch offset);
//                         ex_upd_* are ignored.
//
// Ports
//   clock, reset_n              clock / async active-low reset
//   if_valid, if_pc, if_instr   fetch interface
//   stall                       hold latch contents
//   flush                       squash latch (wins over stall)
//   ex_upd_valid/pc/taken       resolved conditional branch from execute
//   dec_valid, dec_pc           latched instruction status / PC
//   dec_instr                   latched instruction (0 for J)
//   dec_pred_taken              prediction for a latched BNE/BLT
//   rd_addr_a, rd_addr_b        register-file read addresses
//   redirect_valid, redirect_pc fetch redirect
// ----------------------------------------------------------------------------
module fd_decode_stage
   import fd_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int BHT_DEPTH  = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  if_valid,
   input  logic [DATA_W-1:0]     if_pc,
   input  logic [DATA_W-1:0]     if_instr,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  ex_upd_valid,
   input  logic [DATA_W-1:0]     ex_upd_pc,
   input  logic                  ex_upd_taken,
   output logic                  dec_valid,
   output logic [DATA_W-1:0]     dec_pc,
   output logic [DATA_W-1:0]     dec_instr,
   output logic                  dec_pred_taken,
   output logic [REG_ADDR_W-1:0] rd_addr_a,
   output logic [REG_ADDR_W-1:0] rd_addr_b,
   output logic                  redirect_valid,
   output logic [DATA_W-1:0]     redirect_pc
);

   // Latch state
   logic              dec_valid_r;
   logic [DATA_W-1:0] pc_r;
   logic [DATA_W-1:0] instr_r;
   logic              fresh_r;        // first cycle after a load
   logic              squash_pend_r;  // redirect happened under stall; drop next arrival
   logic              pred_hold_r;    // prediction frozen after the fresh cycle

   // Decode
   dec_flags_t        flags_s;
   logic              raw_pred_s;
   logic              pred_s;
   logic              redirect_s;
   logic [DATA_W-1:0] jmp_tgt_s;
   logic [DATA_W-1:0] br_off_s;
   logic [DATA_W-1:0] br_tgt_s;
   logic [DATA_W-1:0] one_s;
   logic [REG_ADDR_W-1:0] rd_b_s;

   assign flags_s = decode_op(instr_r[OP_MSB:OP_LSB]);

   // Prediction source
`ifdef FD_BHT_EN
   localparam int IDX_W = $clog2(BHT_DEPTH);
   logic [1:0] ctr_s;
   logic       unused_upd_s;

   fd_bht #(
      .DEPTH (BHT_DEPTH),
      .IDX_W (IDX_W)
   ) u_bht (
      .clock      (clock),
      .reset_n    (reset_n),
      .lookup_idx (pc_r[IDX_W-1:0]),
      .upd_valid  (ex_upd_valid),
      .upd_idx    (ex_upd_pc[IDX_W-1:0]),
      .upd_taken  (ex_upd_taken),
      .lookup_ctr (ctr_s)
   );

   assign raw_pred_s   = ctr_s[PRED_BIT];
   assign unused_upd_s = ^ex_upd_pc[DATA_W-1:IDX_W];
`else
   localparam int unused_depth = BHT_DEPTH;
   logic unused_upd_s;

   // Backward branches (negative offset) predicted taken
   assign raw_pred_s   = instr_r[IMM_MSB];
   assign unused_upd_s = ^{ex_upd_valid, ex_upd_pc, ex_upd_taken};
`endif

   // The BHT entry may be retrained while the branch sits stalled; the value
   // seen in the fresh cycle is the one that drove the redirect decision, so
   // it is the one reported for the rest of the instruction's stay.
   assign pred_s = fresh_r ? raw_pred_s : pred_hold_r;

   // Targets (pc + 1 + sext(imm17) wraps modulo 2^DATA_W)
   assign one_s     = {{(DATA_W-1){1'b0}}, 1'b1};
   assign jmp_tgt_s = {{(DATA_W-JT_W){1'b0}}, instr_r[JT_MSB:0]};
   assign br_off_s  = {{(DATA_W-IMM_W){instr_r[IMM_MSB]}}, instr_r[IMM_MSB:0]};
   assign br_tgt_s  = pc_r + one_s + br_off_s;

   assign redirect_s = dec_valid_r & fresh_r &
                       (flags_s.jump | flags_s.jal | (flags_s.cond_br & pred_s));

   // Second read address selection
   always_comb begin
      rd_b_s = '0;
      if (flags_s.bex) begin
         rd_b_s = {REG_ADDR_W{1'b1}};
      end else if (flags_s.sw | flags_s.jr | flags_s.cond_br) begin
         rd_b_s = REG_ADDR_W'(instr_r[RB_MSB:RB_LSB]);
      end else begin
         rd_b_s = REG_ADDR_W'(instr_r[RT_MSB:RT_LSB]);
      end
   end

   // Latch update. Priority: flush > stall > squash > load. A redirect that is
   // not stalled squashes the arrival on its own edge; one that is stalled
   // leaves squash_pend set so the first unstalled edge drops the arrival.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dec_valid_r   <= 1'b0;
         pc_r          <= '0;
         instr_r       <= '0;
         fresh_r       <= 1'b0;
         squash_pend_r <= 1'b0;
      end else if (flush) begin
         dec_valid_r   <= 1'b0;
         fresh_r       <= 1'b0;
         squash_pend_r <= 1'b0;
      end else if (stall) begin
         fresh_r       <= 1'b0;
         if (redirect_s) begin
            squash_pend_r <= 1'b1;
         end
      end else if (squash_pend_r | redirect_s) begin
         dec_valid_r   <= 1'b0;
         fresh_r       <= 1'b0;
         squash_pend_r <= 1'b0;
      end else begin
         dec_valid_r   <= if_valid;
         pc_r          <= if_pc;
         instr_r       <= if_instr;
         fresh_r       <= 1'b1;
      end
   end

   // Freeze the prediction at the end of the fresh cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pred_hold_r <= 1'b0;
      end else if (fresh_r) begin
         pred_hold_r <= raw_pred_s;
      end
   end

   // Outputs (combinational from the latch)
   assign dec_valid      = dec_valid_r;
   assign dec_pc         = pc_r;
   assign dec_instr      = flags_s.jump ? '0 : instr_r;
   assign dec_pred_taken = dec_valid_r & flags_s.cond_br & pred_s;
   assign rd_addr_a      = REG_ADDR_W'(instr_r[RA_MSB:RA_LSB]);
   assign rd_addr_b      = rd_b_s;
   assign redirect_valid = redirect_s;
   assign redirect_pc    = redirect_s ? (flags_s.cond_br ? br_tgt_s : jmp_tgt_s) : '0;

endmodule
